// File: rtl/div_seq.sv
// div_seq: multi-cycle sequencer for 32-bit MIPS DIV/DIVU, driven from EX.
// It runs a restoring shift-subtract divide that produces one quotient bit
// per clock. While it runs it raises a stall so that the pipeline holds.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset (0 = reset)
//   start_i       divide request; held high until ready_o is seen
//   annul_i       cancel the current/pending divide (flush or exception)
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//   stallreq_o    pipeline stall request, combinational
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_rem, w_rem_nxt;     // partial remainder
  logic [WIDTH-1:0]   r_quo, w_quo_nxt;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   r_dvsr, w_dvsr_nxt;   // latched divisor magnitude
  logic               r_neg_q, w_neg_q_nxt;
  logic               r_neg_r, w_neg_r_nxt;
  logic [2*WIDTH-1:0] r_result, w_result_nxt;
  logic               r_ready, w_ready_nxt;

  logic [WIDTH:0]     w_shift, w_diff;
  logic [WIDTH-1:0]   w_abs1, w_abs2, w_quo_fix, w_rem_fix;

  // DIV works on magnitudes; the signs are reapplied once the loop is done.
  assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;

  // One restoring step. The partial remainder always stays below the divisor,
  // so WIDTH bits are enough to store it. Only the shifted value needs the
  // extra bit, and the sign of the difference is the restore decision.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};

  assign w_quo_fix = r_neg_q ? ('0 - r_quo) : r_quo;
  assign w_rem_fix = r_neg_r ? ('0 - r_rem) : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_dvsr   <= w_dvsr_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_dvsr_nxt   = r_dvsr;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;

    case (r_state)
      S_FREE: begin
        w_result_nxt = '0;
        w_ready_nxt  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = S_BYZERO;
          end else begin
            w_state_nxt = S_ON;
            w_cnt_nxt   = '0;
            w_rem_nxt   = '0;
            w_quo_nxt   = w_abs1;
            w_dvsr_nxt  = w_abs2;
            w_neg_q_nxt = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            w_neg_r_nxt = signed_div_i && opdata1_i[WIDTH-1];
          end
        end
      end
      S_BYZERO: begin
        w_state_nxt  = S_END;
        w_result_nxt = '0;
        w_ready_nxt  = 1'b1;
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nxt  = S_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end else if (r_cnt != CW'(WIDTH)) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (!w_diff[WIDTH]) begin
            w_rem_nxt = w_diff[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            w_rem_nxt = w_shift[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
          end
        end else begin
          w_state_nxt  = S_END;
          w_result_nxt = {w_rem_fix, w_quo_fix};
          w_ready_nxt  = 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          w_state_nxt  = S_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = S_FREE;
        w_result_nxt = '0;
        w_ready_nxt  = 1'b0;
      end
    endcase
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = ((r_state == S_FREE) && start_i && !annul_i) ||
                      (r_state == S_BYZERO) || (r_state == S_ON);

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq. Each request pushes its reference
// result when it is driven, and that result is popped when ready_o is seen.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb[$];

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result built from the language's own / and % operators.
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, uq, ur;
    if (b == 32'd0) return 64'd0;
    ma = (sd && a[31]) ? -a : a;
    mb = (sd && b[31]) ? -b : b;
    uq = ma / mb;
    ur = ma % mb;
    if (sd && (a[31] ^ b[31])) uq = -uq;
    if (sd && a[31]) ur = -ur;
    return {ur, uq};
  endfunction

  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b, input bit toggle);
    logic [63:0] exp;
    int edges;
    int exp_edges;
    bit stall_ok;
    sb.push_back(model(sd, a, b));
    exp_edges = (b == 32'd0) ? 2 : 34;   // E0 through ready edge, inclusive
    @(negedge clk);
    signed_div_i = sd; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    #1 check("stall_req", 64'(stallreq_o), 64'd1);
    edges = 0;
    stall_ok = 1'b1;
    while (!ready_o && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (!ready_o && !stallreq_o) stall_ok = 1'b0;
      if (toggle && !ready_o) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
    end
    check("stall_busy", 64'(stall_ok), 64'd1);
    check("latency", 64'(edges), 64'(exp_edges));
    check("stall_end", 64'(stallreq_o), 64'd0);
    exp = sb.pop_front();
    check("result", result_o, exp);
    @(posedge clk); #1;
    check("end_hold_rdy", 64'(ready_o), 64'd1);
    check("end_hold_res", result_o, exp);
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    check("drop_rdy", 64'(ready_o), 64'd0);
    check("drop_res", result_o, 64'd0);
  endtask

  initial begin
    bit saw_ready;
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #23;
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk); rst = 1'b1;

    do_div(1'b0, 32'd100, 32'd7, 1'b0);
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0);
    do_div(1'b0, 32'h1234, 32'd0, 1'b0);
    do_div(1'b1, 32'h1234, 32'd0, 1'b0);

    // Annul mid-run: annul_i is sampled at E10, with start_i dropped at the same time.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    check("annul_stall", 64'(stallreq_o), 64'd0);
    check("annul_rdy", 64'(ready_o), 64'd0);
    @(negedge clk); annul_i = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) saw_ready = 1'b1;
    end
    check("annul_no_rdy", 64'(saw_ready), 64'd0);
    do_div(1'b0, 32'd50, 32'd5, 1'b0);

    // Reset asserted mid-run, away from any clock edge.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst = 1'b0; start_i = 1'b0;
    #1;
    check("mid_rst_rdy", 64'(ready_o), 64'd0);
    check("mid_rst_res", result_o, 64'd0);
    check("mid_rst_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk); rst = 1'b1;
    do_div(1'b0, 32'hFFFFFFFF, 32'd3, 1'b0);

    // Signed overflow wraps; operands are scrambled during the run.
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    do_div(1'b1, 32'h80000000, 32'd7, 1'b1);
    do_div(1'b0, 32'hDEADBEEF, 32'h00001234, 1'b1);
    repeat (4) do_div(1'($urandom_range(1)), $urandom, $urandom_range(32'hFFFF) + 32'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
